exmem_skid_stage: RTL
=====================

# exmem_skid_stage

Parametrised EX/MEM pipeline stage for the next-generation core. It replaces the free-running EX/MEM register with a valid/ready-handshaked stage holding a two-entry skid buffer, so a MEM-side stall (for example a multi-cycle data memory) back-pressures EX without a combinational ready path. A synchronous flush kills in-flight instructions. Control outputs are forced to zero whenever no valid instruction is presented, so downstream stages see a clean bubble.

## Interface
- DATA_W, 32, width of ALU result and forwarded rt data
- RD_W, 5, destination register index width
- CTRL_W, 4, control bundle width; bit order {MemRead, MemtoReg, MemWrite, RegWrite}, MSB first

- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  kill all held entries and drop the same-cycle input beat
- in_valid  input  1  EX presents an instruction
- in_ready  output  1  stage can accept; driven straight from a flop
- in_aluresult  input  DATA_W  ALU result
- in_rd  input  RD_W  destination register
- in_ctrl  input  CTRL_W  control bundle
- in_rtdata  input  DATA_W  forwarded rt data (store data)
- out_valid  output  1  MEM-side instruction valid
- out_ready  input  1  MEM consumes the presented instruction
- out_aluresult  output  DATA_W  ALU result of head entry
- out_rd  output  RD_W  destination of head entry
- out_ctrl  output  CTRL_W  head control bundle; all zeros when out_valid=0
- out_rtdata  output  DATA_W  store data of head entry
- occupancy  output  2  number of held entries (0, 1 or 2)

## Operation
- Storage: a main entry that drives the outputs, plus a skid entry. Each entry holds aluresult, rd, ctrl and rtdata.
- Handshake definitions:
  - accept = in_valid & in_ready
  - pop = out_valid & out_ready
- States:
  - EMPTY (occupancy 0)
  - ONE (main valid)
  - FULL (main and skid valid)
- EMPTY:
  - accept -> ONE; input loads into main.
- ONE:
  - accept & !pop -> FULL; input loads into skid.
  - accept & pop -> ONE; input loads into main.
  - !accept & pop -> EMPTY.
  - Otherwise hold.
- FULL:
  - in_ready=0, so accept is impossible.
  - pop -> ONE; skid moves to main.
  - Otherwise hold.
- Ordering is strictly FIFO. No beat is duplicated or lost except by flush.
- in_ready = (state != FULL), registered.
- out_valid = (state != EMPTY).
- Priority order: rst > flush > normal operation.
- Flush:
  - Next state is EMPTY and in_ready=1.
  - The same-cycle accepted beat is discarded.
  - The same-cycle pop still counts as consumed by MEM.
- Data fields of invalid entries keep stale values. out_ctrl is gated to zero when out_valid=0, so MemWrite and RegWrite never assert for a bubble.
- in_valid is ignored when in_ready=0. Upstream must hold its data until accepted.

## Timing
- Reset values after the first clk edge with rst=1:
  - state EMPTY, occupancy 0
  - out_valid 0, in_ready 1
  - out_ctrl 0, out_aluresult 0, out_rd 0, out_rtdata 0
  - skid contents 0
- Latency: a beat accepted at edge N is presented on the outputs after edge N (out_valid=1 in cycle N+1), matching the old single-register timing.
- Throughput is 1 beat per cycle while out_ready=1. Steady state stays at ONE with zero bubbles.
- When out_ready falls with one entry held and in_valid=1:
  - The next beat goes to skid (FULL).
  - in_ready drops after that edge.
  - No beat is lost, even though EX sees ready one cycle late.
- When out_ready rises in FULL:
  - The pop edge moves skid to main.
  - in_ready=1 in the following cycle.
- Flush or rst mid-FULL: both entries are dropped in one edge, out_valid=0 in the next cycle, and there is no partial drain.
- There are no combinational paths from in_valid or out_ready to in_ready.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=4'b0000, occupancy=0, in_ready=1. No beat is captured.
- Streaming: out_ready=1; send 8 beats with aluresult 0x10..0x17 on consecutive cycles -> each appears exactly one cycle later, in order, with its rd, ctrl and rtdata, and no gaps.
- Back-pressure: drop out_ready with beats A=0xA0, B=0xB0, C=0xC0 pending -> state FULL (occupancy 2), in_ready=0, C is held upstream. Raise out_ready -> outputs A, B, C in order; in_ready returns 1 one cycle after the first pop.
- Flush in FULL with in_valid=1 (D=0xD0) -> next cycle out_valid=0, out_ctrl=0, occupancy=0; A, B and D never appear.
- Bubble control: in_valid=0 with in_ctrl=4'b1111 and out_ready=1 -> out_ctrl stays 4'b0000 every cycle the stage is empty.
- Simultaneous accept and pop in ONE: in_aluresult=0x55 while head is 0x44 and out_ready=1 -> 0x44 is consumed, 0x55 is presented next cycle, occupancy stays 1.

Source files
------------

// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline stage: one result register plus a one-entry skid, valid/ready on both sides.
// Latency 1 cycle; in_ready comes straight from a flop, so MEM stalls never form a combinational path back to EX.
module exmem_skid_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_aluresult,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_rtdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_aluresult,
    output logic [RD_W-1:0]   out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_rtdata,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] main_alu, main_rt, skid_alu, skid_rt;
    logic [RD_W-1:0]   main_rd, skid_rd;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

    logic accept, pop;
    logic load_main_in, load_main_skid, load_skid;

    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = (state != EMPTY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != FULL);
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        occupancy      = 2'd0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                occupancy = 2'd1;
                if (accept && !pop) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (accept && pop) begin
                    load_main_in = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                occupancy = 2'd2;
                if (pop) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush drops everything held and the same-cycle input beat; a same-cycle pop already left.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_alu  <= '0;
            main_rd   <= '0;
            main_ctrl <= '0;
            main_rt   <= '0;
            skid_alu  <= '0;
            skid_rd   <= '0;
            skid_ctrl <= '0;
            skid_rt   <= '0;
        end else begin
            if (load_main_in) begin
                main_alu  <= in_aluresult;
                main_rd   <= in_rd;
                main_ctrl <= in_ctrl;
                main_rt   <= in_rtdata;
            end else if (load_main_skid) begin
                main_alu  <= skid_alu;
                main_rd   <= skid_rd;
                main_ctrl <= skid_ctrl;
                main_rt   <= skid_rt;
            end
            if (load_skid) begin
                skid_alu  <= in_aluresult;
                skid_rd   <= in_rd;
                skid_ctrl <= in_ctrl;
                skid_rt   <= in_rtdata;
            end
        end
    end

    assign out_aluresult = main_alu;
    assign out_rd        = main_rd;
    assign out_rtdata    = main_rt;
    // Bubbles must never carry MemWrite/RegWrite downstream.
    assign out_ctrl      = out_valid ? main_ctrl : '0;

endmodule
